fp16_to_fp8_vector_pack: RTL and testbench
==========================================

# fp16_to_fp8_vector_pack

Packs four FP16 lanes back into four FP8 lanes, which is the return path of the FP8 vector multiply datapath. It takes the 64-bit, 4×FP16 result bus, rounds and saturates each lane to E4M3 or E5M2, and emits a 32-bit FP8 vector in the same lane order. The block is a 2-stage valid/ready pipeline and carries a transaction ID. It sits between the multiply/accumulate stage and the activation buffer write port.

## Interface
- `ID_WIDTH`, default 4, width of the transaction tag.
- `clk  input  1`: clock, rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `e5m2mode  input  1`: per-beat format select (1 = E5M2, 0 = E4M3). It is sampled with the data at accept.
- `in_valid  input  1`: an input beat is present.
- `in_ready  output  1`: the block can accept a beat this cycle.
- `vec16  input  64`: four FP16 lanes. Lane i is `[16i+15:16i]`.
- `id  input  ID_WIDTH`: tag, passed through unchanged.
- `out_valid  output  1`: an output beat is present.
- `out_ready  input  1`: downstream accepts the beat.
- `vec8  output  32`: four FP8 lanes. Lane i is `[8i+7:8i]`.
- `id_out  output  ID_WIDTH`: tag of the current output beat.
- `out_sat  output  4`: per lane, set when the lane saturated or produced NaN.
- `sat_count  output  16`: running count of saturated or NaN lanes over all output beats.

## Operation
- **Decode.** Each FP16 lane splits into s (1 bit), e (5 bits, bias 15) and m (10 bits).
- **E4M3 (bias 7, NaN = S.1111.111, max finite = S.1111.110).**
  - e8 = e − 8 (signed 6-bit).
  - Rounding on m: lsb = m[7], guard = m[6], sticky = |m[5:0].
  - If e = 31 and m ≠ 0, output S.1111.111 (NaN).
  - If e = 31 and m = 0, output S.1111.110 (saturate).
  - If e8 ≤ 0, or e = 0, output S.0000.000 (flush to zero).
  - If, after rounding, the mantissa carry raises e8 to 16, or gives e8 = 15 with mant = 111, output S.1111.110.
- **E5M2 (bias 15, max finite = S.11110.11).**
  - e8 = e.
  - Rounding on m: lsb = m[8], guard = m[7], sticky = |m[6:0].
  - If e = 31 and m ≠ 0, output S.11111.11 (NaN).
  - If e = 31 and m = 0, output S.11110.11 (saturate).
  - If e = 0, output S.00000.00 (flush to zero).
  - If a rounding carry pushes e8 to 31, output S.11110.11.
- **Rounding carry.** When the mantissa rounds up past all-ones, e8 increments and the mantissa becomes 0.
- **Sign.** The sign is always preserved, including on zero and NaN.
- **out_sat.** out_sat[i] = 1 when lane i took any saturate or NaN branch.
- **sat_count.** Increments by popcount(out_sat) on each out_valid & out_ready handshake. It saturates at 0xFFFF.
- **Pipeline.**
  - Stage 1 registers the decoded fields, the round decision, the mode and the id.
  - Stage 2 registers the packed vec8, out_sat and id_out.
  - Each stage holds its contents while it is full and its consumer is not ready.
- **Mode.** e5m2mode travels with the beat. Changing it between beats never affects beats already in flight.

## Timing
- **Handshakes.** An input beat is accepted at a rising edge where in_valid & in_ready. An output beat transfers at an edge where out_valid & out_ready.
- **Ready chain.**
  - in_ready = !s1_valid | s2_ready, where s2_ready = !out_valid | out_ready. This path is combinational from out_ready.
  - With both stages empty, in_ready = 1.
- **Latency and throughput.**
  - Latency is 2 cycles: a beat accepted at edge N gives out_valid = 1 after edge N+1 when stage 2 is free.
  - Throughput is 1 beat per cycle while out_ready = 1.
- **Ordering.** Beats are never dropped, duplicated or reordered. vec8, id_out and out_sat stay stable while out_valid & !out_ready.
- **Reset.**
  - Assertion is asynchronous and takes effect immediately, including mid-stream. In-flight beats are discarded.
  - Reset values: out_valid = 0, vec8 = 0, id_out = 0, out_sat = 0, sat_count = 0, internal valids = 0. in_ready reads 1 while reset is held.
- **Simultaneous events.** Accept and emit in the same cycle are allowed, and occupancy is unchanged. A sat_count increment and saturation at 0xFFFF in the same cycle leave the count at 0xFFFF.

## Configuration
- **Macro:** `FP8_PACK_RNE_EN`.
- **Defined:** round-to-nearest-even as specified above. Round up when guard & (sticky | lsb).
- **Undefined:** truncation. Guard and sticky are ignored and no rounding carry occurs. All saturate, NaN and flush rules are unchanged.

## Test plan
- **E4M3 basic.** vec16 = 0x0000_3E00_C000_3C00, e5m2mode = 0, id = 5 → vec8 = 0x003CC038, out_sat = 0, id_out = 5, two cycles after accept.
- **E5M2 rounding.** vec16 lanes {0x3C00, 0x3D00, 0x3D80, 0x3C80}, lane 0 first.
  - With RNE: vec8 = 0x3C3E3D3C.
  - Without RNE: vec8 = 0x3C3D3D3C.
- **E4M3 saturation and NaN.**
  - Lanes {0x7800, 0xFC00, 0x7E00, 0x0400}: lanes 0 and 1 saturate, lane 2 is NaN, lane 3 flushes (0x0400 → 0x00).
  - Result: vec8 = 0x007FFE7E, out_sat = 0b0111, sat_count = 3.
- **Backpressure.** Hold out_ready = 0 and send ids 1, 2, 3 back-to-back.
  - in_ready drops after ids 1 and 2 are accepted, and id 3 is held at the input.
  - Then raise out_ready: id_out sequence is 1, 2, 3 on consecutive cycles, with payload stable while stalled.
- **Reset mid-stream.** Assert rst between edges with two beats in flight → out_valid = 0 and sat_count = 0 immediately. No stale beat appears after deassertion.
- **Counter saturation.** Preload sat_count to 0xFFFE via repeated all-NaN beats (4 flags per beat) → sat_count holds at 0xFFFF and never wraps.

Source files
------------

// File: rtl/fp16_to_fp8_vector_pack.sv
// Four-lane FP16 -> FP8 (E4M3 / E5M2) packer, 2-stage valid/ready pipeline with ID passthrough.
// Define FP8_PACK_RNE_EN for round-to-nearest-even; otherwise mantissas are truncated.
module fp16_to_fp8_vector_pack #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                e5m2mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         vec16,
    input  logic [ID_WIDTH-1:0] id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         vec8,
    output logic [ID_WIDTH-1:0] id_out,
    output logic [3:0]          out_sat,
    output logic [15:0]         sat_count
);

    localparam int LANES = 4;

`ifdef FP8_PACK_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    // Stage-2 lane packing: applies the registered round decision, then the
    // saturate / NaN / flush rules of the selected format. Returns {sat, byte}.
    function automatic logic [8:0] pack_lane(
        input logic       mode,
        input logic       sign,
        input logic       nan,
        input logic       inf,
        input logic [4:0] exp,
        input logic [2:0] mant,
        input logic       rnd
    );
        logic [3:0] m_sum;
        logic [5:0] e_r;
        logic       sat;
        logic [6:0] mag;
        m_sum = 4'd0;
        e_r   = 6'd0;
        sat   = 1'b0;
        mag   = 7'd0;
        if (nan) begin
            sat = 1'b1;
            mag = 7'h7F;
        end else if (!mode) begin
            if (inf) begin
                sat = 1'b1;
                mag = 7'h7E;
            end else if (exp <= 5'd8) begin
                mag = 7'd0;
            end else begin
                m_sum = {1'b0, mant} + {3'd0, rnd};
                e_r   = {1'b0, exp} - 6'd8 + {5'd0, m_sum[3]};
                // E4M3 has no infinity: S.1111.111 is NaN, so it must also saturate.
                if (e_r >= 6'd16 || (e_r == 6'd15 && m_sum[2:0] == 3'b111)) begin
                    sat = 1'b1;
                    mag = 7'h7E;
                end else begin
                    mag = {e_r[3:0], m_sum[2:0]};
                end
            end
        end else begin
            if (inf) begin
                sat = 1'b1;
                mag = 7'h7B;
            end else if (exp == 5'd0) begin
                mag = 7'd0;
            end else begin
                m_sum = {2'd0, mant[1:0]} + {3'd0, rnd};
                e_r   = {1'b0, exp} + {5'd0, m_sum[2]};
                if (e_r == 6'd31) begin
                    sat = 1'b1;
                    mag = 7'h7B;
                end else begin
                    mag = {e_r[4:0], m_sum[1:0]};
                end
            end
        end
        return {sat, sign, mag};
    endfunction

    logic [LANES-1:0]      d_sign, d_nan, d_inf, d_rnd;
    logic [LANES-1:0][4:0] d_exp;
    logic [LANES-1:0][2:0] d_mant;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_dec
            logic [15:0] h;
            logic        lsb, guard, sticky;
            assign h         = vec16[16*gi +: 16];
            assign d_sign[gi] = h[15];
            assign d_exp[gi]  = h[14:10];
            assign d_nan[gi]  = (&h[14:10]) & (|h[9:0]);
            assign d_inf[gi]  = (&h[14:10]) & ~(|h[9:0]);
            assign d_mant[gi] = e5m2mode ? {1'b0, h[9:8]} : h[9:7];
            assign lsb        = e5m2mode ? h[8] : h[7];
            assign guard      = e5m2mode ? h[7] : h[6];
            assign sticky     = e5m2mode ? (|h[6:0]) : (|h[5:0]);
            assign d_rnd[gi]  = RNE_EN & guard & (sticky | lsb);
        end
    endgenerate

    logic                  s1_valid_reg;
    logic                  s1_mode_reg;
    logic [ID_WIDTH-1:0]   s1_id_reg;
    logic [LANES-1:0]      s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_rnd_reg;
    logic [LANES-1:0][4:0] s1_exp_reg;
    logic [LANES-1:0][2:0] s1_mant_reg;

    logic [LANES-1:0][8:0] p_res;
    logic [LANES-1:0][7:0] p_byte;
    logic [LANES-1:0]      p_sat;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
            assign p_res[gi]  = pack_lane(s1_mode_reg, s1_sign_reg[gi], s1_nan_reg[gi],
                                          s1_inf_reg[gi], s1_exp_reg[gi], s1_mant_reg[gi],
                                          s1_rnd_reg[gi]);
            assign p_byte[gi] = p_res[gi][7:0];
            assign p_sat[gi]  = p_res[gi][8];
        end
    endgenerate

    logic        s2_ready;
    logic        in_fire;
    logic        out_fire;
    logic [2:0]  sat_pop;
    logic [16:0] sat_sum;

    assign s2_ready = !out_valid | out_ready;
    assign in_ready = !s1_valid_reg | s2_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign sat_pop  = {2'd0, out_sat[0]} + {2'd0, out_sat[1]} + {2'd0, out_sat[2]} + {2'd0, out_sat[3]};
    assign sat_sum  = {1'b0, sat_count} + {14'd0, sat_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_id_reg    <= '0;
            s1_sign_reg  <= '0;
            s1_nan_reg   <= '0;
            s1_inf_reg   <= '0;
            s1_rnd_reg   <= '0;
            s1_exp_reg   <= '0;
            s1_mant_reg  <= '0;
            out_valid    <= 1'b0;
            vec8         <= '0;
            id_out       <= '0;
            out_sat      <= '0;
            sat_count    <= '0;
        end else begin
            if (in_fire) begin
                s1_mode_reg <= e5m2mode;
                s1_id_reg   <= id;
                s1_sign_reg <= d_sign;
                s1_nan_reg  <= d_nan;
                s1_inf_reg  <= d_inf;
                s1_rnd_reg  <= d_rnd;
                s1_exp_reg  <= d_exp;
                s1_mant_reg <= d_mant;
            end
            s1_valid_reg <= in_fire | (s1_valid_reg & !s2_ready);

            if (s2_ready) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    vec8    <= p_byte;
                    id_out  <= s1_id_reg;
                    out_sat <= p_sat;
                end
            end

            if (out_fire) begin
                sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_fp16_to_fp8_vector_pack.sv
// Bench for fp16_to_fp8_vector_pack: directed vector table, hand sequences and a
// randomized run scored against an integer-arithmetic conversion model.
module tb_fp16_to_fp8_vector_pack;

`ifdef FP8_PACK_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        e5m2mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] vec16;
    logic [3:0]  id;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] vec8;
    logic [3:0]  id_out;
    logic [3:0]  out_sat;
    logic [15:0] sat_count;

    fp16_to_fp8_vector_pack #(.ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .e5m2mode(e5m2mode),
        .in_valid(in_valid), .in_ready(in_ready), .vec16(vec16), .id(id),
        .out_valid(out_valid), .out_ready(out_ready), .vec8(vec8),
        .id_out(id_out), .out_sat(out_sat), .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] v;
        logic        md;
        logic [3:0]  tid;
        logic [31:0] ev8;
        logic [3:0]  esat;
    } vec_t;

    typedef struct {
        logic [31:0] v8;
        logic [3:0]  sat;
        logic [3:0]  tid;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   model_sat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic bit rne_up(input int q, input int r, input int half);
        return RNE && ((r > half) || (r == half && (q % 2) == 1));
    endfunction

    // Reference conversion: split mantissa into kept quotient and dropped remainder.
    function automatic logic [8:0] ref_lane(input logic [15:0] h, input bit md);
        int e, m, q, r, e8, mag;
        bit sat;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        sat = 0;
        mag = 0;
        if (e == 31) begin
            sat = 1;
            mag = (m != 0) ? 127 : (md ? 123 : 126);
        end else if (!md) begin
            e8 = e - 8;
            if (e8 > 0) begin
                q = m / 128; r = m % 128;
                if (rne_up(q, r, 64)) q++;
                if (q == 8) begin q = 0; e8++; end
                if (e8 > 15 || (e8 == 15 && q == 7)) begin sat = 1; mag = 126; end
                else mag = e8 * 8 + q;
            end
        end else if (e != 0) begin
            q = m / 256; r = m % 256; e8 = e;
            if (rne_up(q, r, 128)) q++;
            if (q == 4) begin q = 0; e8++; end
            if (e8 >= 31) begin sat = 1; mag = 123; end
            else mag = e8 * 4 + q;
        end
        return {sat, h[15], 7'(mag)};
    endfunction

    function automatic logic [35:0] ref_vec(input logic [63:0] v, input bit md);
        logic [35:0] res;
        logic [8:0]  l;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            l = ref_lane(v[16*i +: 16], md);
            res[8*i +: 8] = l[7:0];
            res[32 + i]   = l[8];
        end
        return res;
    endfunction

    function automatic logic [15:0] rand_lane();
        logic [15:0] h;
        h = 16'($urandom);
        case ($urandom_range(0, 5))
            0: h[14:10] = 5'd31;
            1: h[14:10] = 5'd0;
            2: h[14:10] = 5'($urandom_range(7, 10));
            3: h[14:10] = 5'($urandom_range(21, 24));
            4: h[14:10] = 5'($urandom_range(28, 30));
            default: ;
        endcase
        return h;
    endfunction

    // One cycle: check sat_count, drive inputs at negedge, then record the handshakes
    // that will happen at the coming posedge.
    task automatic drive(input bit iv, input logic [63:0] v, input bit md, input logic [3:0] tid,
                         input bit ordy, input logic [31:0] ev8, input logic [3:0] esat);
        exp_t e, f;
        int   pc;
        @(negedge clk);
        chk("sat_count", 64'(sat_count), 64'(model_sat));
        in_valid  = iv;
        vec16     = v;
        e5m2mode  = md;
        id        = tid;
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                f = exp_q[0];
                chk(ordy ? "out_vec8" : "stall_vec8", 64'(vec8), 64'(f.v8));
                chk(ordy ? "out_id" : "stall_id", 64'(id_out), 64'(f.tid));
                chk(ordy ? "out_sat" : "stall_sat", 64'(out_sat), 64'(f.sat));
                if (ordy) begin
                    void'(exp_q.pop_front());
                    pc = int'(f.sat[0]) + int'(f.sat[1]) + int'(f.sat[2]) + int'(f.sat[3]);
                    model_sat = (model_sat + pc > 65535) ? 65535 : model_sat + pc;
                end
            end
        end
        if (iv && in_ready) begin
            e.v8 = ev8; e.sat = esat; e.tid = tid;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_m(input bit iv, input logic [63:0] v, input bit md,
                           input logic [3:0] tid, input bit ordy);
        logic [35:0] r;
        r = ref_vec(v, md);
        drive(iv, v, md, tid, ordy, r[31:0], r[35:32]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 32'd0, 4'd0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{64'h0000_3E00_C000_3C00, 1'b0, 4'd5, 32'h003CC038, 4'b0000};
        tbl[1] = '{64'h3C80_3D80_3D00_3C00, 1'b1, 4'd6, RNE ? 32'h3C3E3D3C : 32'h3C3D3D3C, 4'b0000};
        tbl[2] = '{64'h0400_7E00_FC00_7800, 1'b0, 4'd7, 32'h007FFE7E, 4'b0111};
        tbl[3] = '{64'h8001_7BFF_FE00_7C00, 1'b1, 4'd8, 32'h807BFF7B, RNE ? 4'b0111 : 4'b0011};
        tbl[4] = '{64'hC840_48C0_5F41_5F80, 1'b0, 4'd9, RNE ? 32'hD0527E7E : 32'hD0517E7E,
                   RNE ? 4'b0011 : 4'b0001};
        tbl[5] = '{64'h8000_A7FF_2400_2000, 1'b0, 4'd10, RNE ? 32'h80900800 : 32'h808F0800, 4'b0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; vec16 = '0; id = '0; e5m2mode = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_vec8", 64'(vec8), 64'd0);
        chk("rst_id_out", 64'(id_out), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Latency: beat 0 becomes visible after the second edge.
        drive(1'b1, tbl[0].v, tbl[0].md, tbl[0].tid, 1'b1, tbl[0].ev8, tbl[0].esat);
        @(posedge clk); #1;
        chk("latency_after_accept", 64'(out_valid), 64'd0);
        drive(1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 32'd0, 4'd0);
        @(posedge clk); #1;
        chk("latency_second_edge", 64'(out_valid), 64'd1);
        idle(2);

        for (int i = 0; i < 6; i++)
            drive(1'b1, tbl[i].v, tbl[i].md, tbl[i].tid, 1'b1, tbl[i].ev8, tbl[i].esat);
        idle(3);

        // Backpressure: ids 1 and 2 fill the pipe, id 3 waits at the input.
        drive_m(1'b1, {rand_lane(), rand_lane(), rand_lane(), rand_lane()}, 1'b0, 4'd1, 1'b0);
        drive_m(1'b1, {rand_lane(), rand_lane(), rand_lane(), rand_lane()}, 1'b1, 4'd2, 1'b0);
        begin
            logic [63:0] v3;
            v3 = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
            for (int k = 0; k < 3; k++) begin
                drive_m(1'b1, v3, 1'b0, 4'd3, 1'b0);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            end
            drive_m(1'b1, v3, 1'b0, 4'd3, 1'b1);
        end
        chk("bp_seq_id1", 64'({out_valid, id_out}), 64'({1'b1, 4'd1}));
        idle(1);
        chk("bp_seq_id2", 64'({out_valid, id_out}), 64'({1'b1, 4'd2}));
        idle(1);
        chk("bp_seq_id3", 64'({out_valid, id_out}), 64'({1'b1, 4'd3}));
        idle(2);

        for (int k = 0; k < 500; k++)
            drive_m(1'($urandom_range(0, 1)), {rand_lane(), rand_lane(), rand_lane(), rand_lane()},
                    1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset between edges with two beats in flight.
        drive_m(1'b1, {4{16'h7E00}}, 1'b0, 4'd11, 1'b0);
        drive_m(1'b1, {4{16'h7C00}}, 1'b1, 4'd12, 1'b0);
        @(posedge clk); #2;
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sat_count", 64'(sat_count), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        model_sat = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("no_stale_beat", 64'(out_valid), 64'd0);
        end

        // Counter saturation: 16383 all-NaN beats give 65532, +2 gives 0xFFFE.
        for (int k = 0; k < 16383; k++) drive_m(1'b1, {4{16'h7E00}}, 1'b0, 4'(k), 1'b1);
        drive_m(1'b1, {16'h3C00, 16'h3C00, 16'h7E00, 16'h7E00}, 1'b0, 4'd1, 1'b1);
        idle(3);
        chk("sat_count_fffe", 64'(sat_count), 64'hFFFE);
        for (int k = 0; k < 3; k++) drive_m(1'b1, {4{16'hFE00}}, 1'b1, 4'd2, 1'b1);
        idle(4);
        chk("sat_count_hold", 64'(sat_count), 64'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
